// File: rtl/header_parser_pkg.sv
// Shared widths, protocol constants and header byte offsets for the header parser.
package header_parser_pkg;

  localparam int MATCH_KEY_WIDTH = 16;
  localparam int PRIO_SIZE       = 8;
  localparam int CHAIN_SIZE      = 16;
  localparam int TIME_SIZE       = 8;
  localparam int LEN_SIZE        = 16;
  localparam int VALUE_WIDTH     = PRIO_SIZE + TIME_SIZE + CHAIN_SIZE;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] ETH_HDR_LEN    = 16'd14;

  // Byte offsets from the start of the Ethernet frame; IPv4 IHL assumed to be 5.
  localparam int OFF_ETHERTYPE = 12;
  localparam int OFF_IP_LEN    = 16;
  localparam int OFF_IP_PROTO  = 23;
  localparam int OFF_UDP_DPORT = 36;

  typedef struct packed {
    logic [PRIO_SIZE-1:0]  prio;
    logic [TIME_SIZE-1:0]  time_est;
    logic [CHAIN_SIZE-1:0] chain;
  } flow_value_t;

endpackage

// File: rtl/header_parser_match_table.sv
// Flow CAM: parallel key compare, lowest-free-slot allocation, update-in-place on key hit.
module match_table
  import header_parser_pkg::*;
#(
  parameter int TABLE_DEPTH = 16,
  parameter int FLOW_SIZE   = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [MATCH_KEY_WIDTH-1:0] wr_key,
  input  flow_value_t                wr_value,
  input  logic                       lk_en,
  input  logic [MATCH_KEY_WIDTH-1:0] lk_key,
  output logic                       hit,
  output logic [FLOW_SIZE-1:0]       hit_idx,
  output flow_value_t                hit_value
);

  logic [TABLE_DEPTH-1:0]     valid;
  logic [MATCH_KEY_WIDTH-1:0] key_mem [TABLE_DEPTH];
  flow_value_t                val_mem [TABLE_DEPTH];

  logic                 wr_hit;
  logic [FLOW_SIZE-1:0] wr_hit_idx;
  logic                 free_found;
  logic [FLOW_SIZE-1:0] free_idx;
  logic                 wr_do;
  logic [FLOW_SIZE-1:0] wr_idx;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (key_mem[i] == wr_key)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = FLOW_SIZE'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = FLOW_SIZE'(i);
      end
    end
  end

  assign wr_do  = wr_en && (wr_hit || free_found);
  assign wr_idx = wr_hit ? wr_hit_idx : free_idx;

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    hit_value = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (lk_en && valid[i] && (key_mem[i] == lk_key)) begin
        hit       = 1'b1;
        hit_idx   = FLOW_SIZE'(i);
        hit_value = val_mem[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_do) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Payload storage is unreset; an entry is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      key_mem[wr_idx] <= wr_key;
      val_mem[wr_idx] <= wr_value;
    end
  end

endmodule

// File: rtl/header_parser.sv
// Zero-latency header parser: extracts Ethernet/IPv4/UDP fields and looks up the flow table.
module header_parser
  import header_parser_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int TABLE_DEPTH = 16,
  parameter int FLOW_SIZE   = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic                       config_mat_en,
  input  logic [MATCH_KEY_WIDTH-1:0] config_mat_key,
  input  logic [31:0]                config_mat_value,
  output logic [PRIO_SIZE-1:0]       m_desc_prio,
  output logic [CHAIN_SIZE-1:0]      m_desc_chain,
  output logic [TIME_SIZE-1:0]       m_desc_time,
  output logic [LEN_SIZE-1:0]        m_desc_pk_len,
  output logic [FLOW_SIZE-1:0]       m_desc_flow_id
);

  logic [15:0]                ethertype;
  logic [15:0]                ip_len;
  logic [7:0]                 ip_proto;
  logic [MATCH_KEY_WIDTH-1:0] udp_dport;
  logic                       is_ipv4;
  logic                       is_udp;
  logic [LEN_SIZE-1:0]        keep_count;
  logic [LEN_SIZE-1:0]        pk_len;

  logic                 hit;
  logic [FLOW_SIZE-1:0] hit_idx;
  flow_value_t          hit_value;

  // Only the header beat is parsed; tlast and the payload bits are deliberately unused.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tlast, s_axis_tdata};

  assign ethertype = {s_axis_tdata[8*OFF_ETHERTYPE +: 8], s_axis_tdata[8*(OFF_ETHERTYPE+1) +: 8]};
  assign ip_len    = {s_axis_tdata[8*OFF_IP_LEN +: 8],    s_axis_tdata[8*(OFF_IP_LEN+1) +: 8]};
  assign ip_proto  = s_axis_tdata[8*OFF_IP_PROTO +: 8];
  assign udp_dport = {s_axis_tdata[8*OFF_UDP_DPORT +: 8], s_axis_tdata[8*(OFF_UDP_DPORT+1) +: 8]};

  assign is_ipv4 = (ethertype == ETHERTYPE_IPV4);
  assign is_udp  = is_ipv4 && (ip_proto == IP_PROTO_UDP);

  always_comb begin
    keep_count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_count = keep_count + LEN_SIZE'(s_axis_tkeep[i]);
    end
  end

  // IPv4 total length excludes the Ethernet header; wraps at 16 bits.
  assign pk_len = is_ipv4 ? (ip_len + ETH_HDR_LEN) : keep_count;

  match_table #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .FLOW_SIZE   (FLOW_SIZE)
  ) u_match_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (config_mat_en),
    .wr_key    (config_mat_key),
    .wr_value  (flow_value_t'(config_mat_value)),
    .lk_en     (s_axis_tvalid && is_udp),
    .lk_key    (udp_dport),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_value (hit_value)
  );

  always_comb begin
    m_desc_prio    = '0;
    m_desc_chain   = '0;
    m_desc_time    = '0;
    m_desc_pk_len  = '0;
    m_desc_flow_id = '0;
    if (s_axis_tvalid) begin
      m_desc_pk_len = pk_len;
      if (hit) begin
        m_desc_prio    = hit_value.prio;
        m_desc_chain   = hit_value.chain;
        m_desc_time    = hit_value.time_est;
        m_desc_flow_id = hit_idx;
      end
    end
  end

endmodule

// File: tb/tb_header_parser.sv
// Directed self-checking bench for header_parser with hand-computed descriptor values.
module tb_header_parser;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          config_mat_en;
  logic [15:0]   config_mat_key;
  logic [31:0]   config_mat_value;
  logic [7:0]    m_desc_prio;
  logic [15:0]   m_desc_chain;
  logic [7:0]    m_desc_time;
  logic [15:0]   m_desc_pk_len;
  logic [3:0]    m_desc_flow_id;

  int n_cmp = 0;
  int n_err = 0;

  header_parser dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .config_mat_en    (config_mat_en),
    .config_mat_key   (config_mat_key),
    .config_mat_value (config_mat_value),
    .m_desc_prio      (m_desc_prio),
    .m_desc_chain     (m_desc_chain),
    .m_desc_time      (m_desc_time),
    .m_desc_pk_len    (m_desc_pk_len),
    .m_desc_flow_id   (m_desc_flow_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_desc(input string tag, input logic [7:0] prio, input logic [15:0] chain,
                            input logic [7:0] tm, input logic [3:0] flow, input logic [15:0] len);
    check({tag, ".prio"},  32'(m_desc_prio),    32'(prio));
    check({tag, ".chain"}, 32'(m_desc_chain),   32'(chain));
    check({tag, ".time"},  32'(m_desc_time),    32'(tm));
    check({tag, ".flow"},  32'(m_desc_flow_id), 32'(flow));
    check({tag, ".len"},   32'(m_desc_pk_len),  32'(len));
  endtask

  task automatic set_pkt(input logic [15:0] etype, input logic [15:0] iplen,
                         input logic [7:0] proto, input logic [15:0] dport);
    s_axis_tdata = '0;
    s_axis_tdata[8*12 +: 8] = etype[15:8];
    s_axis_tdata[8*13 +: 8] = etype[7:0];
    s_axis_tdata[8*16 +: 8] = iplen[15:8];
    s_axis_tdata[8*17 +: 8] = iplen[7:0];
    s_axis_tdata[8*23 +: 8] = proto;
    s_axis_tdata[8*36 +: 8] = dport[15:8];
    s_axis_tdata[8*37 +: 8] = dport[7:0];
    s_axis_tkeep  = '1;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic udp(input logic [15:0] dport);
    set_pkt(16'h0800, 16'd100, 8'd17, dport);
  endtask

  task automatic cfg_write(input logic [15:0] key, input logic [31:0] value);
    config_mat_en    = 1'b1;
    config_mat_key   = key;
    config_mat_value = value;
    @(posedge clk);
    #1;
    config_mat_en = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tkeep     = '0;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b1;
    config_mat_en    = 1'b0;
    config_mat_key   = '0;
    config_mat_value = '0;
    #2;
    check_desc("rst_idle", 8'h0, 16'h0, 8'h0, 4'h0, 16'd0);
    // Outputs stay combinational during reset.
    udp(16'd5000);
    #1;
    check_desc("rst_udp", 8'h0, 16'h0, 8'h0, 4'h0, 16'd114);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    udp(16'd5000);
    #1;
    check_desc("miss_5000", 8'h0, 16'h0, 8'h0, 4'h0, 16'd114);

    // Write while the lookup is live: the old (empty) contents are seen until the edge.
    config_mat_en    = 1'b1;
    config_mat_key   = 16'd5000;
    config_mat_value = 32'h0A07_0012;
    #1;
    check("same_cycle.chain", 32'(m_desc_chain), 32'h0);
    @(posedge clk);
    #1;
    config_mat_en = 1'b0;
    check_desc("hit_5000", 8'h0A, 16'h0012, 8'h07, 4'h0, 16'd114);

    s_axis_tvalid = 1'b0;
    #1;
    check_desc("tvalid0", 8'h0, 16'h0, 8'h0, 4'h0, 16'd0);

    cfg_write(16'd5000, 32'h0100_0034);
    udp(16'd5000);
    #1;
    check_desc("rewrite_5000", 8'h01, 16'h0034, 8'h00, 4'h0, 16'd114);

    cfg_write(16'd6000, 32'h0203_0044);
    udp(16'd6000);
    #1;
    check_desc("hit_6000", 8'h02, 16'h0044, 8'h03, 4'h1, 16'd114);

    // TCP to a configured port: no lookup, and the length wraps at 16 bits.
    set_pkt(16'h0800, 16'hFFF5, 8'd6, 16'd5000);
    #1;
    check_desc("tcp_wrap", 8'h0, 16'h0, 8'h0, 4'h0, 16'h0003);

    for (int i = 2; i < 16; i++) cfg_write(16'(7000 + i), {8'(i), 8'h0, 16'(16'h0100 + i)});
    cfg_write(16'd8000, 32'h0909_0999);
    udp(16'd8000);
    #1;
    check_desc("full_drop", 8'h0, 16'h0, 8'h0, 4'h0, 16'd114);
    for (int i = 2; i < 16; i++) begin
      udp(16'(7000 + i));
      #1;
      check("full_hit.flow",  32'(m_desc_flow_id), 32'(i));
      check("full_hit.chain", 32'(m_desc_chain),   32'(16'h0100 + i));
    end
    udp(16'd6000);
    #1;
    check("full_6000.flow", 32'(m_desc_flow_id), 32'h1);

    // ARP with UDP-looking bytes at the UDP offsets must not look up.
    set_pkt(16'h0806, 16'd100, 8'd17, 16'd5000);
    s_axis_tkeep = 64'h0000_0000_0FFF_FFFF;
    #1;
    check_desc("arp", 8'h0, 16'h0, 8'h0, 4'h0, 16'd28);

    udp(16'd5000);
    #1;
    check("pre_rst.chain", 32'(m_desc_chain), 32'h0034);
    rst_n = 1'b0;
    #1;
    check("async_rst.chain", 32'(m_desc_chain), 32'h0);
    config_mat_en    = 1'b1;
    config_mat_key   = 16'd9000;
    config_mat_value = 32'h0303_0333;
    @(posedge clk);
    #1;
    config_mat_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_desc("post_rst_5000", 8'h0, 16'h0, 8'h0, 4'h0, 16'd114);
    udp(16'd9000);
    #1;
    check("rst_write_drop.chain", 32'(m_desc_chain), 32'h0);

    cfg_write(16'd9000, 32'h0303_0333);
    cfg_write(16'd9100, 32'h0506_0000);
    udp(16'd9000);
    #1;
    check_desc("after_rst_9000", 8'h03, 16'h0333, 8'h03, 4'h0, 16'd114);
    udp(16'd9100);
    #1;
    check_desc("bypass_9100", 8'h05, 16'h0000, 8'h06, 4'h1, 16'd114);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/header_parser.md
HEADER_PARSER -- requirements
Module: header_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 512: width of the header beat in bits.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8: width of the byte-enable bus.
REQ-003 Parameter TABLE_DEPTH, default 16: number of match-table entries; power of two.
REQ-004 Port clk, input, 1: the single clock; one clock domain; all state on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port s_axis_tdata, input, DATA_WIDTH: first packet beat; byte 0 = bits [7:0] = first wire byte.
REQ-007 Port s_axis_tkeep, input, KEEP_WIDTH: byte enables of the beat.
REQ-008 Port s_axis_tvalid, input, 1: parse request; the beat is a packet header.
REQ-009 Port s_axis_tlast, input, 1: accepted and ignored; only the header beat is parsed.
REQ-010 Port config_mat_en, input, 1: table write strobe.
REQ-011 Port config_mat_key, input, MATCH_KEY_WIDTH (16): UDP destination port to match.
REQ-012 Port config_mat_value, input, 32: [15:0] chain, [23:16] time, [31:24] prio.
REQ-013 Port m_desc_prio, output, PRIO_SIZE (8): priority of matched flow.
REQ-014 Port m_desc_chain, output, CHAIN_SIZE (16): service chain; 0 = bypass.
REQ-015 Port m_desc_time, output, TIME_SIZE (8): service time estimate.
REQ-016 Port m_desc_pk_len, output, LEN_SIZE (16): packet length in bytes.
REQ-017 Port m_desc_flow_id, output, FLOW_SIZE (log2 TABLE_DEPTH): index of matched entry.

Function
REQ-018 Descriptor outputs are combinational from s_axis_* and registered table state, with zero latency; the consumer samples them in the same cycle it raises s_axis_tvalid.
REQ-019 With s_axis_tvalid=0, all descriptor outputs are 0.
REQ-020 IPv4 is detected when bytes 12-13 equal 0x0800 (big-endian).
REQ-021 UDP is detected when the packet is IPv4 and byte 23 equals 17.
REQ-022 For IPv4, pk_len = (byte16<<8 | byte17) + 14, truncated to 16 bits.
REQ-023 For non-IPv4, pk_len = popcount(s_axis_tkeep).
REQ-024 Match key = bytes 36-37 (UDP destination port, big-endian; IHL fixed at 5).
REQ-025 Lookup is valid only for UDP: it compares the key against all valid entries in parallel.
REQ-026 On a hit, prio, chain and time come from the entry, and flow_id = entry index.
REQ-027 On a miss, or for a non-UDP packet, prio, chain, time and flow_id are 0; pk_len is still computed.
REQ-028 Table write on config_mat_en at a clock edge: if the key is already present, overwrite that entry's value; otherwise write the lowest-index free entry and set its valid bit.
REQ-029 A write to a full table with a new key is silently dropped.
REQ-030 The table never holds duplicate keys.
REQ-031 A write and a lookup in the same cycle: the lookup sees the pre-write contents; the new value is visible from the next cycle.
REQ-032 Chain value 0 may be stored; it makes the flow bypass.

Reset
REQ-033 rst_n low clears all valid bits immediately (asynchronously), so every lookup misses.
REQ-034 Entry key and value storage need not be reset.
REQ-035 A config write coinciding with reset is discarded.
REQ-036 Outputs remain combinational during reset, with table-derived fields 0.

Structure
REQ-037 A shared package holds MATCH_KEY_WIDTH, PRIO_SIZE, CHAIN_SIZE, TIME_SIZE, LEN_SIZE, the ethertype/protocol constants and the header byte offsets.
REQ-038 One sub-module, match_table (CAM: parallel compare, priority free-slot search, write logic), is instantiated once.
REQ-039 Field extraction and length computation live in the top level.

Verification
REQ-040 Reset, then UDP packet, dst port 5000, IP length 100, tvalid=1 -> chain=0, prio=0, time=0, flow_id=0, pk_len=114.
REQ-041 Write key 5000 with value 0x0A07_0012, then the same packet next cycle -> prio=0x0A, time=0x07, chain=0x0012, flow_id=0, pk_len=114.
REQ-042 Rewrite key 5000 with value 0x0100_0034 -> same entry updated: flow_id=0, chain=0x0034; a second key 6000 lands in flow_id=1.
REQ-043 Fill 16 distinct keys, then write a 17th -> 17th key misses, all 16 still hit.
REQ-044 ARP frame (ethertype 0x0806) with tkeep=0x0000_0000_0FFF_FFFF -> pk_len=28, chain=0.
REQ-045 Assert rst_n low mid-run, then release -> previously configured key misses.
